// File: rtl/sdiv_seq_param.sv
// Sequential signed divider: restoring shift-subtract on operand magnitudes, one quotient bit per cycle.
// Optional saturation of overflow / divide-by-zero quotients is enabled with SDIV_SATURATE_EN.
module sdiv_seq_param #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned MSB = WIDTH - 1;
  localparam int unsigned CW  = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SMAX = ~SMIN;
`ifdef SDIV_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_reg, b_reg, mag_b, quo, rem;
  logic [CW-1:0]    cnt;
  logic             sign_q, sign_r;

  logic             b_zero, last, ovf_c, load_res;
  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] rem_nx, quo_nx, q_res, r_res;

  // quo starts as |a| and is shifted out MSB-first while quotient bits fill in from the LSB
  always_comb begin
    rem_sh = {rem, quo[MSB]};
    trial  = rem_sh - {1'b0, mag_b};
    rem_nx = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_nx = {quo[MSB-1:0], ~trial[WIDTH]};
  end

  always_comb begin
    b_zero   = (b_reg == '0);
    last     = (cnt == CW'(WIDTH - 1));
    ovf_c    = (a_reg == SMIN) && (b_reg == '1);
    load_res = ((state == PREP) && b_zero) || ((state == CALC) && last);
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = PREP;
      PREP: begin
        busy     = 1'b1;
        state_nx = b_zero ? FIX : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last) state_nx = FIX;
      end
      FIX: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Results are formed from the final step's next values and registered on entry to FIX,
  // so they are already valid in the done cycle.
  always_comb begin
    q_res = sign_q ? -quo_nx : quo_nx;
    r_res = sign_r ? -rem_nx : rem_nx;
    if (SAT && ovf_c) q_res = SMAX;
    if (state == PREP) begin
      q_res = SAT ? (a_reg[MSB] ? SMIN : SMAX) : '1;
      r_res = a_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      mag_b       <= '0;
      quo         <= '0;
      rem         <= '0;
      cnt         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      q           <= '0;
      r           <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          a_reg <= a;
          b_reg <= b;
        end
        PREP: begin
          quo    <= a_reg[MSB] ? -a_reg : a_reg;
          mag_b  <= b_reg[MSB] ? -b_reg : b_reg;
          rem    <= '0;
          cnt    <= '0;
          sign_q <= a_reg[MSB] ^ b_reg[MSB];
          sign_r <= a_reg[MSB];
        end
        CALC: begin
          quo <= quo_nx;
          rem <= rem_nx;
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
      if (load_res) begin
        q           <= q_res;
        r           <= r_res;
        div_by_zero <= (state == PREP);
        overflow    <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_sdiv_seq_param.sv
// Self-checking bench for sdiv_seq_param at WIDTH=8 and WIDTH=4 against an arithmetic reference model.
module tb_sdiv_seq_param;

`ifdef SDIV_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       st8, busy8, done8, dz8, ov8;
  logic [7:0] a8, b8, q8, r8;
  logic       st4, busy4, done4, dz4, ov4;
  logic [3:0] a4, b4, q4, r4;

  sdiv_seq_param #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .busy(busy8), .done(done8),
    .q(q8), .r(r8), .div_by_zero(dz8), .overflow(ov8));

  sdiv_seq_param #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(st4), .a(a4), .b(b4), .busy(busy4), .done(done4),
    .q(q4), .r(r4), .div_by_zero(dz4), .overflow(ov4));

  typedef struct {
    int unsigned q;
    int unsigned r;
    bit          dz;
    bit          ov;
  } res_t;

  int   n_chk  = 0;
  int   n_fail = 0;
  res_t exp8[$];
  res_t exp4[$];
  res_t hold8 = '{default: 0};
  res_t hold4 = '{default: 0};

  task automatic check(input string name, input int unsigned got, input int unsigned want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic int sx(input int w, input int unsigned v);
    int t;
    t = int'(v << (32 - w));
    return t >>> (32 - w);
  endfunction

  function automatic res_t model(input int w, input int unsigned av, input int unsigned bv);
    int sa, sb, mn, mx, qi, ri;
    int unsigned mask;
    res_t o;
    sa   = sx(w, av);
    sb   = sx(w, bv);
    mn   = -(1 << (w - 1));
    mx   = (1 << (w - 1)) - 1;
    mask = (32'd1 << w) - 1;
    o.dz = 1'b0;
    o.ov = 1'b0;
    if (sb == 0) begin
      o.dz = 1'b1;
      ri   = sa;
      qi   = SAT ? ((sa >= 0) ? mx : mn) : -1;
    end else if (sa == mn && sb == -1) begin
      o.ov = 1'b1;
      ri   = 0;
      qi   = SAT ? mx : mn;
    end else begin
      qi = sa / sb;
      ri = sa % sb;
    end
    o.q = int'(qi) & mask;
    o.r = int'(ri) & mask;
    return o;
  endfunction

  // Output tracker: q/r/flags must equal the last expected result on every cycle.
  always @(negedge clk) begin
    if (done8) begin
      if (exp8.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL done8_unexpected: got done=1, expected no result pending at %0t", $time);
      end else hold8 = exp8.pop_front();
    end
    if (done4) begin
      if (exp4.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL done4_unexpected: got done=1, expected no result pending at %0t", $time);
      end else hold4 = exp4.pop_front();
    end
    check("q8_track", q8, hold8.q);
    check("r8_track", r8, hold8.r);
    check("flags8_track", {dz8, ov8}, {hold8.dz, hold8.ov});
    check("q4_track", q4, hold4.q);
    check("r4_track", r4, hold4.r);
    check("flags4_track", {dz4, ov4}, {hold4.dz, hold4.ov});
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic drv(input int sel, input logic s, input int unsigned av, input int unsigned bv);
    if (sel == 0) begin
      st8 = s; a8 = av[7:0]; b8 = bv[7:0];
    end else begin
      st4 = s; a4 = av[3:0]; b4 = bv[3:0];
    end
  endtask

  task automatic run(input int sel, input int unsigned av, input int unsigned bv,
                     input bit noise, input bit fix_start, input bit repulse);
    int   w, lat, n_busy;
    bit   dn, bs, bz;
    res_t e;
    w  = (sel == 0) ? 8 : 4;
    bz = (sx(w, bv) == 0);
    e  = model(w, av, bv);
    if (sel == 0) exp8.push_back(e); else exp4.push_back(e);
    drv(sel, 1'b1, av, bv);
    tick;
    drv(sel, 1'b0, av, bv);
    lat    = 0;
    n_busy = ((sel == 0) ? busy8 : busy4) ? 1 : 0;
    for (int n = 1; n <= w + 4; n++) begin
      tick;
      dn = (sel == 0) ? done8 : done4;
      bs = (sel == 0) ? busy8 : busy4;
      if (dn) begin
        lat = n + 1;
        check("busy_at_done", bs, 0);
        break;
      end
      if (bs) n_busy++;
      if (repulse && n == 3) drv(sel, 1'b1, 9, 3);
      else if (noise) drv(sel, 1'($urandom_range(0, 1)), $urandom, $urandom);
      else drv(sel, 1'b0, av, bv);
    end
    check("latency", lat, bz ? 2 : w + 2);
    check("busy_cycles", n_busy, bz ? 1 : w + 1);
    drv(sel, fix_start, av, bv);
    tick;
    drv(sel, 1'b0, av, bv);
    if (fix_start) check("start_in_fix_ignored", (sel == 0) ? busy8 : busy4, 0);
  endtask

  task automatic check_res8(input string name, input int unsigned eq, input int unsigned er,
                            input bit edz, input bit eov);
    check({name, "_q"}, q8, eq);
    check({name, "_r"}, r8, er);
    check({name, "_flags"}, {dz8, ov8}, {edz, eov});
  endtask

  initial begin
    res_t m;
    int unsigned ra, rb;
    int k;
    rst = 1'b0;
    drv(0, 1'b0, 0, 0);
    drv(1, 1'b0, 0, 0);
    repeat (3) tick;
    check("rst_busy_done8", {busy8, done8}, 0);
    check("rst_out8", {q8, r8, dz8, ov8}, 0);
    check("rst_busy_done4", {busy4, done4}, 0);
    check("rst_out4", {q4, r4, dz4, ov4}, 0);
    rst = 1'b1;
    tick;

    m = model(8, 'h9C, 7);
    check("model_pin_q", m.q, 'hF2);
    check("model_pin_r", m.r, 'hFE);

    run(0, 100, 7, 0, 0, 0);
    check_res8("pos_pos", 'h0E, 'h02, 0, 0);
    run(0, 'h9C, 7, 0, 0, 0);
    check_res8("neg_pos", 'hF2, 'hFE, 0, 0);
    run(0, 100, 'hF9, 0, 0, 0);
    check_res8("pos_neg", 'hF2, 'h02, 0, 0);
    run(0, 'h9C, 'hF9, 0, 1, 0);
    check_res8("neg_neg", 'h0E, 'hFE, 0, 0);
    run(0, 'h80, 'hFF, 0, 0, 0);
    check_res8("overflow", SAT ? 'h7F : 'h80, 'h00, 0, 1);
    run(0, 5, 0, 0, 0, 0);
    check_res8("div_zero", SAT ? 'h7F : 'hFF, 'h05, 1, 0);
    run(0, 100, 7, 0, 0, 1);
    check_res8("repulse_ignored", 'h0E, 'h02, 0, 0);

    drv(0, 1'b1, 50, 3);
    tick;
    drv(0, 1'b0, 50, 3);
    repeat (4) tick;
    rst = 1'b0;
    exp8.delete();
    exp4.delete();
    hold8 = '{default: 0};
    hold4 = '{default: 0};
    #1;
    check("abort_busy_done", {busy8, done8}, 0);
    check_res8("abort_clear", 0, 0, 0, 0);
    tick;
    rst = 1'b1;
    tick;
    run(0, 9, 3, 0, 0, 0);
    check_res8("after_reset", 3, 0, 0, 0);

    run(1, 'h9, 2, 0, 1, 0);
    check("w4_q", q4, 'hD);
    check("w4_r", r4, 'hF);
    run(1, 7, 'hE, 0, 0, 0);
    check("w4_b2b_q", q4, 'hD);
    check("w4_b2b_r", r4, 'h1);

    for (int i = 0; i < 40; i++) begin
      k  = $urandom_range(0, 9);
      ra = $urandom;
      rb = $urandom;
      if (k == 0) rb = 0;
      if (k == 1) begin ra = 'h80; rb = 'hFF; end
      run(0, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end
    for (int i = 0; i < 30; i++) begin
      run(1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end

    repeat (3) tick;
    check("pending_results", exp8.size() + exp4.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sdiv_seq_param.md
Name: sdiv_seq_param

Overview:
Parametrised sequential signed divider, the next generation of the team's fixed 4-bit signed division block. Takes two WIDTH-bit two's-complement operands on a start pulse and runs a restoring shift-subtract divider on their magnitudes, one bit per cycle. It returns a truncated-toward-zero quotient and a remainder carrying the dividend's sign, with divide-by-zero and overflow flags. Sits in the calculator datapath beside the multiply/add blocks and is driven by the same start/done control sequencer.

Parameters:
WIDTH, 8, operand/quotient/remainder width in bits; legal range 4 to 32.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low; clears all state
start  input  1  one-cycle request; sampled only in IDLE
a  input  WIDTH  signed dividend, captured on accepted start
b  input  WIDTH  signed divisor, captured on accepted start
busy  output  1  high from the cycle after accepted start until done is asserted
done  output  1  one-cycle pulse; q, r and flags are valid from this cycle on
q  output  WIDTH  signed quotient
r  output  WIDTH  signed remainder
div_by_zero  output  1  set with done when b == 0
overflow  output  1  set with done when a == -2^(WIDTH-1) and b == -1

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; busy, done, q, r, div_by_zero and overflow are all 0. Asserting reset mid-operation aborts the division and discards partial results.
- FSM states: IDLE, PREP, CALC, FIX.
- IDLE: on start=1, latch a and b and go to PREP. With start=0, stay in IDLE.
- PREP (1 cycle): form unsigned magnitudes |a| and |b| (WIDTH bits; |−2^(WIDTH-1)| = 2^(WIDTH-1) fits unsigned), store sign_q = a[MSB]^b[MSB] and sign_r = a[MSB], and clear the iteration counter.
  - If b == 0, go to FIX with the dbz flag set and skip CALC.
  - Otherwise go to CALC.
- CALC (exactly WIDTH cycles): restoring step per cycle.
  - Partial remainder (WIDTH+1 bits) shifts left and takes in the next dividend MSB.
  - Subtract |b|. If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - When the counter reaches WIDTH-1, go to FIX.
- FIX (1 cycle): register the outputs, pulse done=1 and return to IDLE.
  - q = sign_q ? −mag_q : mag_q, truncated to WIDTH bits.
  - r = sign_r ? −mag_r : mag_r.
  - div_by_zero = dbz; overflow = (a == −2^(WIDTH-1)) && (b == all ones).
- Latency:
  - Normal division: done is high WIDTH+2 cycles after the cycle in which start was sampled.
  - Divide-by-zero: done is high 2 cycles after start.
- Divide-by-zero result: q = all ones (−1), r = a, overflow = 0.
- Overflow result (without the optional feature): q = −2^(WIDTH-1) (wrapped), r = 0.
- busy is high in PREP and CALC only; it is 0 in the FIX/done cycle.
- start while busy is ignored, and the operands are not re-latched.
- start in the same cycle as done (FIX) is ignored; a new start is accepted once the FSM is back in IDLE.
- q, r and the flags hold their values until the next FIX or reset.
- Changes on a or b after capture have no effect on the operation in progress.

Optional Feature:
SDIV_SATURATE_EN.
- Defined: an overflow result saturates to q = 2^(WIDTH-1)−1 with r = 0. A divide-by-zero result saturates to q = 2^(WIDTH-1)−1 when a ≥ 0 and q = −2^(WIDTH-1) when a < 0, with r = a. The flags are unchanged.
- Undefined: the wrap/all-ones results described in Behaviour apply.

Test Plan:
WIDTH=8, a=100, b=7, start pulse -> done 10 cycles after start; q=0x0E (14), r=0x02, both flags 0; busy high for 9 cycles.
WIDTH=8, a=−100 (0x9C), b=7 -> q=0xF2 (−14), r=0xFE (−2). Then a=100, b=−7 -> q=0xF2, r=0x02. Then a=−100, b=−7 -> q=0x0E, r=0xFE.
WIDTH=8, a=−128 (0x80), b=−1 (0xFF) -> overflow=1, q=0x80, r=0x00; with SDIV_SATURATE_EN, q=0x7F.
WIDTH=8, a=5, b=0 -> done 2 cycles after start; div_by_zero=1, q=0xFF, r=0x05; with SDIV_SATURATE_EN, q=0x7F.
WIDTH=8, a=100, b=7 started; start re-pulsed with a=9, b=3 at cycle 4, and rst pulsed low during a later run at cycle 5 -> first result is still q=14, r=2 (second start ignored). After the reset all outputs are 0, and a following start with a=9, b=3 gives q=3, r=0.
WIDTH=4, a=−7 (0x9), b=2 -> done 6 cycles after start; q=0xD (−3), r=0xF (−1); back-to-back start on the cycle after done is accepted.
